pset01_clk_div_bank: RTL and testbench

//   Bank of NUM_CH independent programmable clock dividers with per-channel output polarity.

---
 rtl/pset01_clk_div_bank.sv | 77 +++++++
 tb/tb_pset01_clk_div_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pset01_clk_div_bank.sv
// Bank of NUM_CH independent programmable clock-enable dividers.
// Each channel toggles its output every (div+1) enabled cycles and emits a one-cycle tick with each toggle.
module pset01_clk_div_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 0,
    parameter int CH_W    = ($clog2(NUM_CH) > 0 ? $clog2(NUM_CH) : 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] inv,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  div_r       [NUM_CH];
    logic [CNT_W-1:0]  cnt_r       [NUM_CH];
    logic [NUM_CH-1:0] phase_r;

    logic [CNT_W-1:0]  div_nxt_s   [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s   [NUM_CH];
    logic [NUM_CH-1:0] phase_nxt_s;
    logic [NUM_CH-1:0] tick_nxt_s;
    logic              wr_valid_s;

    // Zero-extend the index so out-of-range selects are detectable for non-power-of-two banks.
    assign wr_valid_s = wr_en && ({1'b0, wr_ch} < NUM_CH_L);

    // Per-channel next state: a write beats a terminal count, disable discards the partial count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_nxt_s[i]   = div_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            phase_nxt_s[i] = phase_r[i];
            tick_nxt_s[i]  = 1'b0;
            if (wr_valid_s && (wr_ch == CH_W'(i))) begin
                div_nxt_s[i] = wr_div;
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (!en[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == div_r[i]) begin
                cnt_nxt_s[i]   = {CNT_W{1'b0}};
                phase_nxt_s[i] = ~phase_r[i];
                tick_nxt_s[i]  = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // State and registered outputs; polarity is applied on the registered output only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_r[i] <= DEF_DIV_L;
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            phase_r <= {NUM_CH{1'b0}};
            out     <= {NUM_CH{1'b0}};
            tick    <= {NUM_CH{1'b0}};
        end else begin
            div_r   <= div_nxt_s;
            cnt_r   <= cnt_nxt_s;
            phase_r <= phase_nxt_s;
            out     <= phase_nxt_s ^ inv;
            tick    <= tick_nxt_s;
        end
    end

endmodule

// File: tb/tb_pset01_clk_div_bank.sv
// Self-checking bench for pset01_clk_div_bank: directed vector table, hand sequences and
// randomized traffic against a run-length reference model, on a 4-channel and a 5-channel build.
module tb_pset01_clk_div_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  en, inv, out, tick;
    logic        wr_en5;
    logic [2:0]  wr_ch5;
    logic [4:0]  en5, inv5, out5, tick5;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per channel, the divider and the number of enabled edges since the last restart.
    int unsigned     m_div   [2][8];
    longint unsigned m_run   [2][8];
    bit              m_phase [2][8];
    bit              m_out   [2][8];
    bit              m_tick  [2][8];

    typedef struct {
        bit          rst;
        bit          wr_en;
        logic [1:0]  wr_ch;
        logic [15:0] wr_div;
        logic [3:0]  en;
        logic [3:0]  inv;
        logic [3:0]  exp_out;
        logic [3:0]  exp_tick;
    } vec_t;

    vec_t tbl [10];

    pset01_clk_div_bank u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .en(en), .inv(inv), .out(out), .tick(tick)
    );

    pset01_clk_div_bank #(.NUM_CH(5)) u_dut5 (
        .clk(clk), .rst(rst), .wr_en(wr_en5), .wr_ch(wr_ch5), .wr_div(wr_div),
        .en(en5), .inv(inv5), .out(out5), .tick(tick5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int m, input int nch, input bit r, input bit we,
                              input int wch, input int unsigned wd, input logic [7:0] env,
                              input logic [7:0] invv);
        for (int i = 0; i < nch; i++) begin
            if (r) begin
                m_div[m][i] = 0; m_run[m][i] = 0; m_phase[m][i] = 1'b0; m_tick[m][i] = 1'b0;
            end else if (we && wch == i) begin
                m_div[m][i] = wd; m_run[m][i] = 0; m_tick[m][i] = 1'b0;
            end else if (!env[i]) begin
                m_run[m][i] = 0; m_tick[m][i] = 1'b0;
            end else begin
                m_run[m][i]++;
                m_tick[m][i] = ((m_run[m][i] % (longint'(m_div[m][i]) + 1)) == 0);
                if (m_tick[m][i]) m_phase[m][i] = ~m_phase[m][i];
            end
            m_out[m][i] = r ? 1'b0 : (m_phase[m][i] ^ invv[i]);
        end
    endtask

    // One clock edge: capture inputs, advance the model, sample #1 after the edge and compare.
    task automatic step(input string tag);
        bit r = rst;
        bit we = wr_en, we5 = wr_en5;
        int wch = int'(wr_ch), wch5 = int'(wr_ch5);
        int unsigned wd = wr_div;
        logic [7:0] e4 = {4'h0, en}, i4 = {4'h0, inv}, e5 = {3'h0, en5}, i5 = {3'h0, inv5};
        logic [7:0] eo, et, eo5, et5;
        @(posedge clk);
        model_edge(0, 4, r, we, wch, wd, e4, i4);
        model_edge(1, 5, r, we5, wch5, wd, e5, i5);
        #1;
        eo = 8'h00; et = 8'h00; eo5 = 8'h00; et5 = 8'h00;
        for (int i = 0; i < 4; i++) begin eo[i] = m_out[0][i]; et[i] = m_tick[0][i]; end
        for (int i = 0; i < 5; i++) begin eo5[i] = m_out[1][i]; et5[i] = m_tick[1][i]; end
        check({tag, "_out"},   {4'h0, out},   eo);
        check({tag, "_tick"},  {4'h0, tick},  et);
        check({tag, "_out5"},  {3'h0, out5},  eo5);
        check({tag, "_tick5"}, {3'h0, tick5}, et5);
    endtask

    initial begin
        logic prev;
        int   c;
        rst = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0; en = 4'h0; inv = 4'h0;
        wr_en5 = 1'b0; wr_ch5 = 3'd0; en5 = 5'h00; inv5 = 5'h00;

        // Reset with everything enabled/inverted, release, then div=0 on ch0.
        tbl[0] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'h0, 4'hF, 4'hF, 4'h0};
        tbl[4] = '{1'b0, 1'b1, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'h1, 4'h0, 4'h1, 4'h1};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'h1, 4'h0, 4'h0, 4'h1};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'h1, 4'h0, 4'h1, 4'h1};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'h1, 4'h0, 4'h0, 4'h1};
        tbl[9] = '{1'b0, 1'b1, 2'd1, 16'd4, 4'h0, 4'h0, 4'h0, 4'h0};

        for (int k = 0; k < 10; k++) begin
            rst = tbl[k].rst; wr_en = tbl[k].wr_en; wr_ch = tbl[k].wr_ch;
            wr_div = tbl[k].wr_div; en = tbl[k].en; inv = tbl[k].inv;
            step("tbl");
            check($sformatf("tbl%0d_out", k),  {4'h0, out},  {4'h0, tbl[k].exp_out});
            check($sformatf("tbl%0d_tick", k), {4'h0, tick}, {4'h0, tbl[k].exp_tick});
        end
        wr_en = 1'b0;

        // ch1 div=4: tick every 5 cycles, 10-cycle period, four full periods.
        en = 4'b0010;
        for (int s = 1; s <= 40; s++) begin
            step("div4");
            check("div4_tick1", {7'h0, tick[1]}, {7'h0, ((s % 5) == 0)});
            check("div4_out1",  {7'h0, out[1]},  {7'h0, ((s / 5) % 2 == 1)});
        end

        // Write div=1 exactly on the terminal-count edge: no toggle, then toggles every 2.
        for (int s = 1; s <= 4; s++) step("pre_term");
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
        step("term_wr");
        check("term_wr_tick1", {7'h0, tick[1]}, 8'h00);
        check("term_wr_out1",  {7'h0, out[1]},  8'h00);
        wr_en = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            step("div1");
            check("div1_tick1", {7'h0, tick[1]}, {7'h0, ((t % 2) == 0)});
            check("div1_out1",  {7'h0, out[1]},  {7'h0, ((t / 2) % 2 == 1)});
        end

        // ch2 div=3: run, disable 7 cycles with an inv flip, then re-enable.
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd3;
        step("wr_ch2");
        wr_en = 1'b0; en = 4'b0110;
        for (int s = 0; s < 10; s++) step("ch2_run");
        en[2] = 1'b0;
        step("ch2_off"); step("ch2_off");
        prev = out[2];
        inv[2] = 1'b1;
        step("ch2_inv");
        check("inv_flip_out2",  {7'h0, out[2]},  {7'h0, ~prev});
        check("inv_flip_tick2", {7'h0, tick[2]}, 8'h00);
        for (int s = 0; s < 4; s++) step("ch2_off");
        en[2] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            step("ch2_reen");
            check("reen_tick2", {7'h0, tick[2]}, {7'h0, (t == 4)});
        end

        // Maximum divider: no tick in a short window, counter must not wrap early.
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'hFFFF;
        step("wr_max");
        wr_en = 1'b0; en[3] = 1'b1;
        for (int s = 0; s < 30; s++) begin
            step("max");
            check("max_tick3", {7'h0, tick[3]}, 8'h00);
        end

        // 5-channel build: out-of-range writes (5, 7) must not disturb ch0 running div=2.
        wr_en5 = 1'b1; wr_ch5 = 3'd0; wr_div = 16'd2;
        step("w5");
        wr_en5 = 1'b0; en5 = 5'b00001;
        c = 0;
        for (int s = 0; s < 14; s++) begin
            if (s == 6) begin wr_en5 = 1'b1; wr_ch5 = 3'd5; wr_div = 16'd0; end
            if (s == 7) wr_ch5 = 3'd7;
            if (s == 8) wr_en5 = 1'b0;
            step("oor");
            c++;
            check("oor_tick5_0", {7'h0, tick5[0]}, {7'h0, ((c % 3) == 0)});
        end

        // Randomized traffic on both builds against the model.
        for (int s = 0; s < 800; s++) begin
            rst    = ($urandom_range(0, 149) == 0);
            wr_en  = ($urandom_range(0, 7) == 0);
            wr_ch  = 2'($urandom_range(0, 3));
            wr_div = 16'($urandom_range(0, 6));
            wr_en5 = ($urandom_range(0, 7) == 0);
            wr_ch5 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) en  = 4'($urandom);
            if ($urandom_range(0, 9) == 0) en5 = 5'($urandom);
            if ($urandom_range(0, 15) == 0) inv  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) inv5 = 5'($urandom);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
